// File: rtl/uart_cmd_ctrl_if.sv
// Receive-byte strobe and register-write handshake between the UART harness and
// the command-frame controller.
interface uart_cmd_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;

  // Controller side: consumes bytes, drives write beats.
  modport master (
    input  rx_valid,
    input  rx_data,
    input  wr_ready,
    output wr_valid,
    output wr_addr,
    output wr_data
  );

  // Harness side: supplies bytes, sinks write beats.
  modport slave (
    output rx_valid,
    output rx_data,
    output wr_ready,
    input  wr_valid,
    input  wr_addr,
    input  wr_data
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command-frame parser behind the UART receiver: SYNC ADDR LEN payload CHK frames are
// checksum-verified, buffered, then replayed as address/data write beats.
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 100000
) (
  input  logic            clk,
  input  logic            reset,
  uart_cmd_ctrl_if.master bus,
  output logic            busy,
  output logic            frame_ok,
  output logic            frame_err,
  output logic [7:0]      err_count
);

  localparam int unsigned IW       = $clog2(MAX_LEN + 1);
  localparam int unsigned AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned BufDepth = 2 ** AW;
  localparam int unsigned TW       = $clog2(TIMEOUT_CLKS);

  localparam logic [AW-1:0] FirstIdx = '0;
  localparam logic [TW-1:0] TmoLast  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StPayload,
    StCheck,
    StWrite
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [IW-1:0] len_q, len_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] idx_inc;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_valid_q, wr_valid_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          buf_we;
  logic          err;
  logic          last_idx;
  logic          in_frame;

  logic [7:0]    buf_q [BufDepth];

  assign idx_inc  = idx_q + IW'(1);
  assign last_idx = (idx_q == len_q - IW'(1));
  assign in_frame = (state_q == StAddr) || (state_q == StLen) ||
                    (state_q == StPayload) || (state_q == StCheck);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    chk_d       = chk_q;
    tmo_d       = tmo_q;
    wr_valid_d  = wr_valid_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    buf_we      = 1'b0;
    err         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          state_d = StAddr;
          tmo_d   = '0;
        end
      end
      StAddr: begin
        if (bus.rx_valid) begin
          addr_d  = bus.rx_data;
          chk_d   = bus.rx_data;
          tmo_d   = '0;
          state_d = StLen;
        end
      end
      StLen: begin
        if (bus.rx_valid) begin
          tmo_d = '0;
          if ((bus.rx_data == 8'h00) || (32'(bus.rx_data) > MAX_LEN)) begin
            err     = 1'b1;
            state_d = StIdle;
          end else begin
            len_d   = IW'(bus.rx_data);
            chk_d   = chk_q ^ bus.rx_data;
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (bus.rx_valid) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ bus.rx_data;
          tmo_d  = '0;
          if (last_idx) begin
            idx_d   = '0;
            state_d = StCheck;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      StCheck: begin
        if (bus.rx_valid) begin
          tmo_d = '0;
          if (bus.rx_data == chk_q) begin
            // Beat 0 is presented in the very next cycle.
            idx_d      = '0;
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = buf_q[FirstIdx];
            state_d    = StWrite;
          end else begin
            err     = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StWrite: begin
        // Bytes arriving mid-replay are dropped; the replay itself carries on.
        if (bus.rx_valid) begin
          err = 1'b1;
        end
        if (wr_valid_q && bus.wr_ready) begin
          if (last_idx) begin
            wr_valid_d = 1'b0;
            frame_ok_d = 1'b1;
            state_d    = StIdle;
          end else begin
            idx_d     = idx_inc;
            wr_addr_d = wr_addr_q + 8'd1;
            wr_data_d = buf_q[idx_inc[AW-1:0]];
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // An arriving byte always beats a coincident timeout expiry.
    if (in_frame && !bus.rx_valid) begin
      if (tmo_q == TmoLast) begin
        err     = 1'b1;
        tmo_d   = '0;
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (err) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      tmo_q       <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      chk_q       <= chk_d;
      tmo_q       <= tmo_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Payload storage has no reset; it is only read after a checksum pass.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[idx_q[AW-1:0]] <= bus.rx_data;
    end
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q != StIdle);
  assign frame_ok     = frame_ok_q;
  assign frame_err    = frame_err_q;
  assign err_count    = err_cnt_q;

endmodule
